// File: rtl/wts_mem_arbiter.sv
// -----------------------------------------------------------------------------
// wts_mem_arbiter
//
// Shares the single external cartridge memory (2MB, 8KB x 256 banks) between
// the MSX slot-side CPU path (bank-mapped, read/write) and the wave-table
// sound engine's waveform fetch (read-only). Each access holds mem_ncs low
// for ACCESS_CYCLES clocks, followed by one RECOVER clock in which the
// granted requester sees a single-cycle acknowledge. When both requesters
// are pending in IDLE, the one not served last wins (round-robin).
//
// Ports
//   clk, nreset              system clock, asynchronous active-low reset
//   cpu_req/cpu_wr           CPU request (level until cpu_ack), 1 = write
//   cpu_bank/cpu_a           bank (address[20:13]) and offset (address[12:0])
//   cpu_wdata                CPU write data
//   cpu_ack/cpu_rdata        completion pulse, read data held until next read
//   wts_req/wts_a            sound-engine fetch request and byte address
//   wts_ack/wts_rdata        completion pulse, fetched byte held until next
//   mem_ncs/mem_noe/mem_nwe  active-low memory strobes
//   mem_a/mem_dout           memory address and write data
//   mem_dout_en              1 = drive the memory data bus
//   mem_din                  read data from memory
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module wts_mem_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 3  // legal range 2..15
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_bank,
  input  logic [12:0] cpu_a,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  input  logic        wts_req,
  input  logic [20:0] wts_a,
  output logic        wts_ack,
  output logic [7:0]  wts_rdata,
  output logic        mem_ncs,
  output logic        mem_noe,
  output logic        mem_nwe,
  output logic [20:0] mem_a,
  output logic [7:0]  mem_dout,
  output logic        mem_dout_en,
  input  logic [7:0]  mem_din
);

  typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;
  typedef enum logic {GRANT_CPU, GRANT_WTS} grant_t;

  localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

  state_t      state, state_n;
  grant_t      last_grant, last_grant_n;  // requester served most recently
  logic        wr_q, wr_n;                // latched direction of current access
  logic [3:0]  cnt, cnt_n;                // cycle index within ACCESS
  logic        take_cpu;

  logic        mem_ncs_n, mem_noe_n, mem_nwe_n, mem_dout_en_n;
  logic [20:0] mem_a_n;
  logic [7:0]  mem_dout_n;
  logic        cpu_ack_n, wts_ack_n;
  logic [7:0]  cpu_rdata_n, wts_rdata_n;

  // Next-state and next-output logic. The strobes are computed one clock
  // ahead so that the flops present them exactly in the cycle they belong to.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned; an unassigned path in always_comb infers a latch.
    state_n       = state;
    last_grant_n  = last_grant;
    wr_n          = wr_q;
    cnt_n         = cnt;
    take_cpu      = 1'b0;
    mem_ncs_n     = 1'b1;
    mem_noe_n     = 1'b1;
    mem_nwe_n     = 1'b1;
    mem_dout_en_n = 1'b0;
    mem_a_n       = mem_a;
    mem_dout_n    = mem_dout;
    cpu_ack_n     = 1'b0;
    wts_ack_n     = 1'b0;
    cpu_rdata_n   = cpu_rdata;
    wts_rdata_n   = wts_rdata;

    case (state)
      IDLE: begin
        if (cpu_req || wts_req) begin
          // CPU wins when alone, or on a tie when WTS was served last.
          take_cpu      = cpu_req && (!wts_req || last_grant == GRANT_WTS);
          state_n       = ACCESS;
          cnt_n         = 4'd0;
          mem_ncs_n     = 1'b0;
          if (take_cpu) begin
            last_grant_n  = GRANT_CPU;
            wr_n          = cpu_wr;
            mem_a_n       = {cpu_bank, cpu_a};
            mem_dout_n    = cpu_wdata;
            mem_noe_n     = cpu_wr;
            mem_dout_en_n = cpu_wr;
          end else begin
            last_grant_n  = GRANT_WTS;
            wr_n          = 1'b0;
            mem_a_n       = wts_a;
            mem_noe_n     = 1'b0;
          end
        end
      end

      ACCESS: begin
        if (cnt == LAST_CNT) begin
          // Edge ending the last access cycle: sample read data, release
          // the strobes and raise the owner's acknowledge for RECOVER.
          state_n = RECOVER;
          if (last_grant == GRANT_CPU) begin
            cpu_ack_n = 1'b1;
            if (!wr_q) cpu_rdata_n = mem_din;
          end else begin
            wts_ack_n   = 1'b1;
            wts_rdata_n = mem_din;
          end
        end else begin
          cnt_n         = 4'(cnt + 4'd1);
          mem_ncs_n     = 1'b0;
          mem_noe_n     = wr_q;
          mem_dout_en_n = wr_q;
          // The first access cycle is address setup; WE drops from the second.
          mem_nwe_n     = !wr_q;
        end
      end

      RECOVER: state_n = IDLE;

      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state       <= IDLE;
      last_grant  <= GRANT_WTS;
      wr_q        <= 1'b0;
      cnt         <= 4'd0;
      mem_ncs     <= 1'b1;
      mem_noe     <= 1'b1;
      mem_nwe     <= 1'b1;
      mem_dout_en <= 1'b0;
      mem_a       <= 21'd0;
      mem_dout    <= 8'd0;
      cpu_ack     <= 1'b0;
      wts_ack     <= 1'b0;
      cpu_rdata   <= 8'd0;
      wts_rdata   <= 8'd0;
    end else begin
      state       <= state_n;
      last_grant  <= last_grant_n;
      wr_q        <= wr_n;
      cnt         <= cnt_n;
      mem_ncs     <= mem_ncs_n;
      mem_noe     <= mem_noe_n;
      mem_nwe     <= mem_nwe_n;
      mem_dout_en <= mem_dout_en_n;
      mem_a       <= mem_a_n;
      mem_dout    <= mem_dout_n;
      cpu_ack     <= cpu_ack_n;
      wts_ack     <= wts_ack_n;
      cpu_rdata   <= cpu_rdata_n;
      wts_rdata   <= wts_rdata_n;
    end
  end

endmodule

// File: tb/tb_wts_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wts_mem_arbiter
//
// Self-checking bench for wts_mem_arbiter. The bench acts as the external
// memory (a sparse byte array written from the pins) and keeps a separate
// reference memory updated from the transactions it issues. Expected strobe
// waveforms come from the access timing rules: grant at edge k, strobes for
// ACCESS_CYCLES cycles, acknowledge in the following cycle, IDLE after that.
// -----------------------------------------------------------------------------
module tb_wts_mem_arbiter;

  localparam int AC = 3;
  localparam int PERIOD = AC + 2;

  logic        clk, nreset;
  logic        cpu_req, cpu_wr;
  logic [7:0]  cpu_bank;
  logic [12:0] cpu_a;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        wts_req;
  logic [20:0] wts_a;
  logic        wts_ack;
  logic [7:0]  wts_rdata;
  logic        mem_ncs, mem_noe, mem_nwe, mem_dout_en;
  logic [20:0] mem_a;
  logic [7:0]  mem_dout, mem_din;

  int tests = 0;
  int fails = 0;

  logic [7:0] cpu_rd_exp = 8'h00;
  logic [7:0] wts_rd_exp = 8'h00;

  logic [7:0] phys_mem [logic [20:0]];
  logic [7:0] ref_mem  [logic [20:0]];

  wts_mem_arbiter #(.ACCESS_CYCLES(AC)) dut (
    .clk(clk), .nreset(nreset),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_bank(cpu_bank), .cpu_a(cpu_a),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .wts_req(wts_req), .wts_a(wts_a), .wts_ack(wts_ack), .wts_rdata(wts_rdata),
    .mem_ncs(mem_ncs), .mem_noe(mem_noe), .mem_nwe(mem_nwe), .mem_a(mem_a),
    .mem_dout(mem_dout), .mem_dout_en(mem_dout_en), .mem_din(mem_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unwritten locations hold an address-dependent pattern.
  function automatic logic [7:0] dflt(input logic [20:0] a);
    return a[7:0] ^ a[15:8] ^ {3'b000, a[20:16]} ^ 8'h5A;
  endfunction

  function automatic logic [7:0] phys_rd(input logic [20:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : dflt(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [20:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  // External memory: writes land while CS and WE are low; read data follows
  // the address, settled well before the capturing rising edge.
  always @(negedge clk) begin
    if (!mem_ncs && !mem_nwe && mem_dout_en) phys_mem[mem_a] = mem_dout;
    mem_din = phys_rd(mem_a);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic preload(input logic [20:0] a, input logic [7:0] d);
    phys_mem[a] = d;
    ref_mem[a]  = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction, started at #1 after an edge with the DUT idle.
  // Control vector order: {ncs, noe, nwe, dout_en, cpu_ack, wts_ack}.
  task automatic run_xact(input bit is_cpu, input bit wr, input logic [20:0] addr,
                          input logic [7:0] wdata, input string tag);
    logic [5:0] ctl, exp_ctl;
    logic [7:0] rd_exp;
    rd_exp = ref_rd(addr);
    if (is_cpu) begin
      cpu_wr = wr; cpu_bank = addr[20:13]; cpu_a = addr[12:0];
      cpu_wdata = wdata; cpu_req = 1'b1;
    end else begin
      wts_a = addr; wts_req = 1'b1;
    end
    for (int i = 1; i <= AC + 1; i++) begin
      tick();
      if (i == 1) begin
        // Disturb the request inputs; the latched transaction must not move.
        cpu_bank = 8'($urandom); cpu_a = 13'($urandom);
        cpu_wdata = 8'($urandom); wts_a = 21'($urandom);
      end
      ctl = {mem_ncs, mem_noe, mem_nwe, mem_dout_en, cpu_ack, wts_ack};
      if (i <= AC) exp_ctl = {1'b0, wr, !(wr && i >= 2), wr, 2'b00};
      else         exp_ctl = {4'b1110, is_cpu, !is_cpu};
      tests++;
      if (ctl !== exp_ctl) begin
        fails++;
        $display("FAIL %s ctl step %0d: got %b want %b (ncs,noe,nwe,den,cack,wack)",
                 tag, i, ctl, exp_ctl);
      end
      if (i <= AC) begin
        tests++;
        if (mem_a !== addr) begin
          fails++;
          $display("FAIL %s mem_a step %0d: got %h want %h", tag, i, mem_a, addr);
        end
        if (wr) begin
          tests++;
          if (mem_dout !== wdata) begin
            fails++;
            $display("FAIL %s mem_dout step %0d: got %h want %h", tag, i, mem_dout, wdata);
          end
        end
      end
    end
    if (is_cpu) begin
      cpu_req = 1'b0;
      if (!wr) cpu_rd_exp = rd_exp;
    end else begin
      wts_req = 1'b0;
      wts_rd_exp = rd_exp;
    end
    if (wr) ref_mem[addr] = wdata;
    tests++;
    if (cpu_rdata !== cpu_rd_exp || wts_rdata !== wts_rd_exp) begin
      fails++;
      $display("FAIL %s rdata: got cpu=%h wts=%h want cpu=%h wts=%h",
               tag, cpu_rdata, wts_rdata, cpu_rd_exp, wts_rd_exp);
    end
    tick();
    ctl = {mem_ncs, mem_noe, mem_nwe, mem_dout_en, cpu_ack, wts_ack};
    tests++;
    if (ctl !== 6'b111000) begin
      fails++;
      $display("FAIL %s after ack: ctl got %b want 111000", tag, ctl);
    end
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    cpu_req = 1'b0; cpu_wr = 1'b0; cpu_bank = 8'h00; cpu_a = 13'h0000;
    cpu_wdata = 8'h00; wts_req = 1'b0; wts_a = 21'h0;
    repeat (2) tick();
    tests++;
    if ({mem_ncs, mem_noe, mem_nwe, mem_dout_en, cpu_ack, wts_ack} !== 6'b111000 ||
        mem_a !== 21'd0 || mem_dout !== 8'd0 || cpu_rdata !== 8'd0 || wts_rdata !== 8'd0) begin
      fails++;
      $display("FAIL reset values: ctl=%b mem_a=%h dout=%h crd=%h wrd=%h",
               {mem_ncs, mem_noe, mem_nwe, mem_dout_en, cpu_ack, wts_ack},
               mem_a, mem_dout, cpu_rdata, wts_rdata);
    end
    nreset = 1'b1;
    repeat (2) tick();
    tests++;
    if ({mem_ncs, mem_noe, mem_nwe, mem_dout_en, cpu_ack, wts_ack} !== 6'b111000) begin
      fails++;
      $display("FAIL idle without requests: ctl=%b want 111000",
               {mem_ncs, mem_noe, mem_nwe, mem_dout_en, cpu_ack, wts_ack});
    end
  endtask

  task automatic test_cpu_read();
    preload(21'h024001, 8'hA5);
    run_xact(1'b1, 1'b0, {8'h12, 13'h0001}, 8'h00, "cpu_read");
    tests++;
    if (cpu_rdata !== 8'hA5) begin
      fails++;
      $display("FAIL cpu_read data: got %h want a5", cpu_rdata);
    end
  endtask

  task automatic test_cpu_write();
    run_xact(1'b1, 1'b1, {8'hFF, 13'h1FFF}, 8'h3C, "cpu_write");
    tests++;
    if (phys_rd(21'h1FFFFF) !== 8'h3C) begin
      fails++;
      $display("FAIL cpu_write memory: got %h want 3c", phys_rd(21'h1FFFFF));
    end
  endtask

  task automatic test_wts_fetch();
    preload(21'h000100, 8'h7E);
    run_xact(1'b0, 1'b0, 21'h000100, 8'h00, "wts_fetch");
    tests++;
    if (wts_rdata !== 8'h7E || cpu_rdata !== 8'hA5) begin
      fails++;
      $display("FAIL wts_fetch data: got wts=%h cpu=%h want wts=7e cpu=a5",
               wts_rdata, cpu_rdata);
    end
  endtask

  // Both requesters continuously busy from reset release. Transaction n is
  // granted at edge n*PERIOD after release; even n belong to the CPU.
  task automatic test_round_robin();
    logic [20:0] ca, wa;
    logic [5:0]  ctl, exp_ctl;
    int n, o;
    bit who_cpu;
    ca = {8'h12, 13'h0055};
    wa = 21'h1ABCD;
    preload(ca, 8'hC3);
    preload(wa, 8'h96);
    nreset = 1'b0;
    cpu_wr = 1'b0; cpu_bank = ca[20:13]; cpu_a = ca[12:0];
    wts_a = wa; cpu_req = 1'b1; wts_req = 1'b1;
    tick();
    nreset = 1'b1;
    cpu_rd_exp = 8'h00; wts_rd_exp = 8'h00;
    for (int t = 0; t < 4 * PERIOD; t++) begin
      tick();
      n = t / PERIOD;
      o = t % PERIOD;
      who_cpu = (n % 2) == 0;
      if (o < AC)       exp_ctl = 6'b001000;
      else if (o == AC) exp_ctl = {4'b1110, who_cpu, !who_cpu};
      else              exp_ctl = 6'b111000;
      ctl = {mem_ncs, mem_noe, mem_nwe, mem_dout_en, cpu_ack, wts_ack};
      tests++;
      if (ctl !== exp_ctl) begin
        fails++;
        $display("FAIL round_robin ctl t=%0d: got %b want %b", t, ctl, exp_ctl);
      end
      if (o < AC) begin
        tests++;
        if (mem_a !== (who_cpu ? ca : wa)) begin
          fails++;
          $display("FAIL round_robin mem_a t=%0d: got %h want %h",
                   t, mem_a, who_cpu ? ca : wa);
        end
      end
      if (o == AC) begin
        if (who_cpu) cpu_rd_exp = 8'hC3;
        else         wts_rd_exp = 8'h96;
        tests++;
        if (cpu_rdata !== cpu_rd_exp || wts_rdata !== wts_rd_exp) begin
          fails++;
          $display("FAIL round_robin rdata t=%0d: got cpu=%h wts=%h want cpu=%h wts=%h",
                   t, cpu_rdata, wts_rdata, cpu_rd_exp, wts_rd_exp);
        end
      end
      // Requester behaviour: drop on ack, raise again the following cycle.
      if (cpu_ack) cpu_req = 1'b0; else if (!cpu_req) cpu_req = 1'b1;
      if (wts_ack) wts_req = 1'b0; else if (!wts_req) wts_req = 1'b1;
    end
    cpu_req = 1'b0;
    wts_req = 1'b0;
    tick();
  endtask

  task automatic test_bank_sweep();
    for (int b = 0; b < 256; b++) begin
      for (int a = 0; a < 2; a++) begin
        run_xact(1'b1, 1'b0, {8'(b), 13'(a)}, 8'h00, "bank_sweep");
      end
    end
  endtask

  task automatic test_reset_mid_access();
    logic [20:0] addr;
    addr = {8'h40, 13'h0ABC};
    cpu_wr = 1'b0; cpu_bank = addr[20:13]; cpu_a = addr[12:0]; cpu_req = 1'b1;
    tick();
    tick();
    tests++;
    if (mem_ncs !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid access started: mem_ncs got %b want 0", mem_ncs);
    end
    nreset = 1'b0;
    #1;
    tests++;
    if ({mem_ncs, mem_noe, mem_nwe, mem_dout_en, cpu_ack, wts_ack} !== 6'b111000 ||
        mem_a !== 21'd0 || mem_dout !== 8'd0 || cpu_rdata !== 8'd0 || wts_rdata !== 8'd0) begin
      fails++;
      $display("FAIL reset_mid async: ctl=%b mem_a=%h dout=%h crd=%h wrd=%h",
               {mem_ncs, mem_noe, mem_nwe, mem_dout_en, cpu_ack, wts_ack},
               mem_a, mem_dout, cpu_rdata, wts_rdata);
    end
    cpu_rd_exp = 8'h00;
    wts_rd_exp = 8'h00;
    tick();
    tick();
    nreset = 1'b1;
    // Request still pending: it is served as a fresh transaction.
    run_xact(1'b1, 1'b0, addr, 8'h00, "reset_mid_after");
  endtask

  task automatic test_random();
    bit          is_cpu, wr;
    logic [20:0] addr;
    logic [5:0]  ctl;
    for (int k = 0; k < 60; k++) begin
      is_cpu = 1'($urandom);
      wr     = is_cpu ? 1'($urandom) : 1'b0;
      addr   = {($urandom_range(0, 1) == 0) ? 8'h03 : 8'hFF, 13'($urandom_range(0, 7))};
      run_xact(is_cpu, wr, addr, 8'($urandom), "random");
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        tick();
        ctl = {mem_ncs, mem_noe, mem_nwe, mem_dout_en, cpu_ack, wts_ack};
        tests++;
        if (ctl !== 6'b111000) begin
          fails++;
          $display("FAIL random idle gap: ctl got %b want 111000", ctl);
        end
      end
    end
  endtask

  initial begin
    mem_din = 8'h00;
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_wts_fetch();
    test_round_robin();
    test_bank_sweep();
    test_reset_mid_access();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
